// File: rtl/aes128_mix_column_ctrl.sv
// aes128_mix_column_ctrl
// Sequences one AES MixColumns / InvMixColumns column transform through a single
// shared external GF(2^8) multiplier. The 16 coefficient x byte products are
// visited row-major (row outer, column inner) and XOR-accumulated per output row.
// Forward-mode coefficients equal to 1 are folded in directly without a gmul call.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start_i; outputs hold the last result
// ISSUE | one cycle per term: either bypass (coef==1) or gmul start pulse
// WAIT  | gmul call in flight; operands held until gmul_valid_i
// DONE  | valid_o high for this single cycle, then back to IDLE

module aes128_mix_column_ctrl (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        inverse_i,
    input  logic [31:0] col_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] col_o,
    output logic [7:0]  gmul_a_o,
    output logic [7:0]  gmul_b_o,
    output logic        gmul_start_o,
    input  logic [7:0]  gmul_result_i,
    input  logic        gmul_valid_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e      state_q;
    logic [1:0]  row_q;
    logic [1:0]  cidx_q;
    logic [7:0]  acc_q;
    logic [31:0] col_in_q;
    logic        inv_q;
    logic        busy_q;
    logic        valid_q;
    logic [31:0] col_out_q;
    logic [7:0]  gmul_a_q;
    logic [7:0]  gmul_b_q;
    logic        gmul_start_q;

    // Circulant coefficient matrix: coef[r][c] = base[(c - r) mod 4].
    function automatic logic [7:0] coef_f(input logic inv, input logic [1:0] r,
                                          input logic [1:0] c);
        logic [1:0] idx;
        idx = c - r;
        case (idx)
            2'd0:    coef_f = inv ? 8'd14 : 8'd2;
            2'd1:    coef_f = inv ? 8'd11 : 8'd3;
            2'd2:    coef_f = inv ? 8'd13 : 8'd1;
            default: coef_f = inv ? 8'd9  : 8'd1;
        endcase
    endfunction

    // Byte c of a column; byte 0 sits in the most significant lane.
    function automatic logic [7:0] byte_f(input logic [31:0] col, input logic [1:0] c);
        case (c)
            2'd0:    byte_f = col[31:24];
            2'd1:    byte_f = col[23:16];
            2'd2:    byte_f = col[15:8];
            default: byte_f = col[7:0];
        endcase
    endfunction

    logic       last_c;
    logic       last_term;
    logic [1:0] row_d;
    logic [1:0] cidx_d;
    logic [7:0] coef_cur;
    logic [7:0] coef_d;
    logic [7:0] term;
    logic [7:0] acc_d;
    logic       step;

    // Next term indices, current/next coefficients and the accumulator update.
    always_comb begin
        last_c    = (cidx_q == 2'd3);
        last_term = last_c && (row_q == 2'd3);
        row_d     = last_c ? row_q + 2'd1 : row_q;
        cidx_d    = last_c ? 2'd0 : cidx_q + 2'd1;
        coef_cur  = coef_f(inv_q, row_q, cidx_q);
        coef_d    = coef_f(inv_q, row_d, cidx_d);
        term      = (state_q == WAIT) ? gmul_result_i : byte_f(col_in_q, cidx_q);
        acc_d     = acc_q ^ term;
        step      = ((state_q == ISSUE) && (coef_cur == 8'd1)) ||
                    ((state_q == WAIT) && gmul_valid_i);
    end

    // Controller FSM with registered handshake and result outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            row_q        <= 2'd0;
            cidx_q       <= 2'd0;
            acc_q        <= 8'd0;
            col_in_q     <= 32'd0;
            inv_q        <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            col_out_q    <= 32'd0;
            gmul_a_q     <= 8'd0;
            gmul_b_q     <= 8'd0;
            gmul_start_q <= 1'b0;
        end else begin
            gmul_start_q <= 1'b0;
            valid_q      <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        col_in_q     <= col_i;
                        inv_q        <= inverse_i;
                        row_q        <= 2'd0;
                        cidx_q       <= 2'd0;
                        acc_q        <= 8'd0;
                        busy_q       <= 1'b1;
                        state_q      <= ISSUE;
                        // The diagonal coefficient (2 or 14) is never 1, so the
                        // first term always needs the multiplier.
                        gmul_a_q     <= coef_f(inverse_i, 2'd0, 2'd0);
                        gmul_b_q     <= col_i[31:24];
                        gmul_start_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (!step) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Fold the current term in and move to the next (row, column).
            if (step) begin
                if (last_c) begin
                    col_out_q[{~row_q, 3'b000} +: 8] <= acc_d;
                    acc_q  <= 8'd0;
                    cidx_q <= 2'd0;
                end else begin
                    acc_q  <= acc_d;
                    cidx_q <= cidx_d;
                end

                if (last_term) begin
                    state_q <= DONE;
                    valid_q <= 1'b1;
                end else begin
                    row_q   <= row_d;
                    state_q <= ISSUE;
                    // Operands are only refreshed for real calls so they stay put
                    // across bypass cycles.
                    if (coef_d != 8'd1) begin
                        gmul_a_q     <= coef_d;
                        gmul_b_q     <= byte_f(col_in_q, cidx_d);
                        gmul_start_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign busy_o       = busy_q;
    assign valid_o      = valid_q;
    assign col_o        = col_out_q;
    assign gmul_a_o     = gmul_a_q;
    assign gmul_b_o     = gmul_b_q;
    assign gmul_start_o = gmul_start_q;

endmodule
